serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 106 ++++++++++
 tb/tb_serial_adder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder step per clock (sum = XOR, carry = AND cell pair plus
// a registered carry-in), LSB first, with a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             half_s, half_c;
  logic             bit_s, bit_c;
  logic [WIDTH-1:0] psum_shift;

  // Two half-adder cells chained through the carry flop form the per-bit full adder.
  assign half_s     = opa_q[0] ^ opb_q[0];
  assign half_c     = opa_q[0] & opb_q[0];
  assign bit_s      = half_s ^ c_q;
  assign bit_c      = half_c | (c_q & half_s);
  assign psum_shift = {bit_s, psum_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    c_d     = c_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          psum_d  = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        psum_d = psum_shift;
        opa_d  = {1'b0, opa_q[WIDTH-1:1]};
        opb_d  = {1'b0, opb_q[WIDTH-1:1]};
        c_d    = bit_c;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = psum_shift;
          carry_d = bit_c;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy  = (state_q == SHIFT);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: the driver queues hand-computed results with the
// cycle on which done must be seen; a separate monitor pops and compares on each done.
module tb_serial_adder;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, carry;
  logic [W-1:0] sum;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  logic [W-1:0] prev_sum = '0;
  logic         prev_carry = 1'b0;
  exp_t sb[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .carry(carry)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done is checked against the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && done) chk("busy_and_done", 1, 0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sum", 32'(sum), 32'(e.s));
          chk("carry", 32'(carry), 32'(e.c));
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          $display("[TB] done: sum=0x%02h carry=%0d cycle=%0d", sum, carry, cyc);
          prev_sum   = e.s;
          prev_carry = e.c;
        end
      end
    end
  end

  // mode 0: plain; 1: operands changed after acceptance; 2: start re-pulsed while busy
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] es, input logic ec, input int mode);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    a = va;
    b = vb;
    e.s = es;
    e.c = ec;
    e.cyc = cyc + 1 + W;
    sb.push_back(e);
    $display("[TB] issue a=0x%02h b=0x%02h mode=%0d expect sum=0x%02h carry=%0d", va, vb, mode, es, ec);
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      chk("busy_high", 32'(busy), 1);
      chk("sum_hold", 32'({carry, sum}), 32'({prev_carry, prev_sum}));
      if (i == 1) begin
        start = 1'b0;
        if (mode == 1) begin
          a = 8'h33;
          b = 8'h33;
        end
      end
      if (mode == 2 && i == 3) begin
        start = 1'b1;
        a = 8'hAA;
        b = 8'hAA;
      end
      if (mode == 2 && i == 4) start = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int base;
    // Reset state
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_carry", 32'(carry), 0);
    idle(2);
    rst = 1'b0;
    idle(1);

    run_op(8'h00, 8'h00, 8'h00, 1'b0, 0);
    idle(2);
    run_op(8'hFF, 8'h01, 8'h00, 1'b1, 0);
    idle(2);
    run_op(8'hA5, 8'h5A, 8'hFF, 1'b0, 0);
    run_op(8'h80, 8'h80, 8'h00, 1'b1, 1);
    idle(2);
    run_op(8'h0F, 8'h01, 8'h10, 1'b0, 2);
    idle(4);

    // Reset mid-operation: outputs clear at once, no done follows.
    @(negedge clk);
    start = 1'b1;
    a = 8'h12;
    b = 8'h34;
    @(negedge clk);
    start = 1'b0;
    idle(3);
    #2 rst = 1'b1;
    #1;
    chk("async_busy", 32'(busy), 0);
    chk("async_done", 32'(done), 0);
    chk("async_sum", 32'(sum), 0);
    chk("async_carry", 32'(carry), 0);
    $display("[TB] reset asserted mid-operation");
    prev_sum = '0;
    prev_carry = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(W + 4);
    run_op(8'h3C, 8'h0E, 8'h4A, 1'b0, 0);
    idle(2);

    // Continuous start: accepted in DONE, one result every W+1 cycles.
    @(negedge clk);
    start = 1'b1;
    a = 8'h01;
    b = 8'h02;
    base = cyc + 1;
    for (int j = 0; j < 3; j++) begin
      exp_t e;
      e.s = 8'h03;
      e.c = 1'b0;
      e.cyc = base + W + j * (W + 1);
      sb.push_back(e);
    end
    $display("[TB] issue continuous start a=0x01 b=0x02 x3 expect sum=0x03");
    while (cyc < base + 2 * (W + 1)) begin
      @(negedge clk);
      if (cyc == base + W + 1) chk("busy_after_done", 32'(busy), 1);
    end
    start = 1'b0;

    for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
